mul_pipe_ctrl: RTL and testbench
================================

# mul_pipe_ctrl

Pipelined sequential wrapper for the RV32M multiply path in the EX stage. It accepts MUL/MULH/MULHSU/MULHU operations over a valid/ready handshake and conditions the operands to unsigned magnitudes. The team's unsigned 32x32 `dadda_tree` core sits between pipeline registers, and the block applies sign correction and high/low word selection. It delivers a 32-bit result with its destination tag to the EX/MEM writeback mux.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `flush`  in  1  synchronous pipeline kill (branch mispredict / trap).
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  block can accept this cycle.
- `rs1_data`  in  32  multiplicand.
- `rs2_data`  in  32  multiplier.
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- `rd_addr`  in  5  destination tag, carried unchanged.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `out_data`  out  32  selected result word.
- `out_rd`  out  5  tag matching `out_data`.
- `busy`  out  1  any pipeline stage holds a valid operation.

## Operation
- Stage S1 (register written on accept):
  - rs1 is signed for MULH and MULHSU; rs2 is signed for MULH only. MUL and MULHU treat both operands as unsigned, because the low word is sign-independent.
  - A signed operand with bit31=1 is replaced by its two's-complement magnitude. 0x80000000 maps to 0x80000000 as an unsigned value, which is correct.
  - The negate flag is set when exactly one operand was negated.
  - S1 stores the two magnitudes, the negate flag, the word-select flag (hi = funct3 != 000), and rd.
- `dadda_tree` is combinational from the S1 magnitudes and produces a 64-bit unsigned product.
- Stage S2 register stores the product, negate flag, hi flag and rd.
- Result logic: p = negate ? (~prod + 1) : prod, 64-bit wrap. `out_data` = hi ? p[63:32] : p[31:0].
- `funct3[2]` is ignored; upstream guarantees that only multiply ops are sent.
- Stall control:
  - advance = !out_valid || out_ready. All stages move together when advance is high and hold when it is low.
  - `in_ready` = advance.
  - A stage whose predecessor is empty loads a bubble (valid=0).
- Flush:
  - On a `flush` edge, every stage valid is cleared.
  - An `in_valid` handshake in the same cycle is discarded.
  - Flush has priority over stall.
  - Data registers may keep stale values; only the valids matter.
- Reset clears all valids. `out_data`=0, `out_rd`=0, `out_valid`=0, `busy`=0, `in_ready`=1.

## Timing
- Throughput is 1 op/cycle when `out_ready` is held high.
- Latency without the macro is 2 cycles: an op accepted at edge k has `out_valid` high in the cycle after edge k+1.
- With the macro, latency is 3 cycles.
- Results leave in issue order. No op is lost or duplicated under backpressure.
- Simultaneous `out_ready` and `in_valid` while full: the output retires and the input is accepted on the same edge.
- Reset asserted mid-operation: all in-flight ops are dropped immediately and asynchronously. After `rst_n` rises, the first edge may accept a new op.
- `busy` = OR of all stage valids. It is registered state only and has no input-to-output path.

## Configuration
- `MUL_OUT_REG_EN` defined: adds stage S3, which registers `out_data` and `out_rd`, taking the negate/select logic off the writeback path.
  - S3 follows the same advance/flush rules.
  - Latency is 3; capacity is 3 ops.
- Undefined: `out_data` is combinational from S2. Latency is 2; capacity is 2 ops.

## Test plan
- MUL, rs1=0x00000007, rs2=0xFFFFFFFD, `out_ready`=1 -> `out_data`=0xFFFFFFEB exactly 2 cycles after accept (3 with the macro); `out_rd` echoes the tag.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULH 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF (product 0xFFFFFFFF_00000001). MULHU with the same operands -> 0xFFFFFFFE.
- Back-to-back issue of 4 MULs with tags 1..4, `out_ready` low for 5 cycles mid-stream:
  - `in_ready` drops once the pipeline is full.
  - Results emerge in order 1..4 with correct values; none are dropped or duplicated.
- `flush` pulsed with 2 ops in flight and a concurrent `in_valid` -> `out_valid` stays 0, and `busy`=0 the next cycle. The next accepted op completes normally.
- `rst_n` pulled low mid-pipeline -> all outputs reach their reset values with no clock edge, and no stale result appears after release.

Source files
------------

// File: rtl/mul_pipe_ctrl.sv
// mul_pipe_ctrl: pipelined RV32M multiply wrapper (MUL/MULH/MULHSU/MULHU).
// Operands are reduced to unsigned magnitudes in S1. An unsigned 32x32
// dadda_tree core forms the product into S2. Sign correction and word
// selection are applied on the way out.
// Optional feature: define MUL_OUT_REG_EN to add an S3 output register.
// That raises latency to 3 and capacity to 3 ops.

// Unsigned 32x32 -> 64 multiplier core. It is purely combinational.
module dadda_tree (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] prod_o
);
    logic [63:0] a_ext;
    logic [63:0] b_ext;

    assign a_ext  = {32'd0, a_i};
    assign b_ext  = {32'd0, b_i};
    assign prod_o = a_ext * b_ext;
endmodule

module mul_pipe_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        busy
);
    // The whole pipe moves in lockstep. It holds only when the head is
    // waiting on the consumer.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // ---------------- operand conditioning (feeds S1) ----------------
    logic        rs1_signed;
    logic        rs2_signed;
    logic        rs1_neg;
    logic        rs2_neg;
    logic [31:0] rs1_mag;
    logic [31:0] rs2_mag;

    // Decide signedness per op, then take magnitudes of negative operands.
    // MUL is treated as unsigned because the low word does not depend on
    // signedness. 0x80000000 negates to itself, which is its correct
    // unsigned magnitude.
    always_comb begin
        rs1_signed = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
        rs2_signed = (funct3[1:0] == 2'b01);
        rs1_neg    = rs1_signed && rs1_data[31];
        rs2_neg    = rs2_signed && rs2_data[31];
        rs1_mag    = rs1_neg ? (~rs1_data + 32'd1) : rs1_data;
        rs2_mag    = rs2_neg ? (~rs2_data + 32'd1) : rs2_data;
    end

    // ---------------- stage S1 ----------------
    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_a_q, s1_a_d;
    logic [31:0] s1_b_q, s1_b_d;
    logic        s1_neg_q, s1_neg_d;
    logic        s1_hi_q, s1_hi_d;
    logic [4:0]  s1_rd_q, s1_rd_d;

    // S1 next state. Flush wins over everything. Data only moves on advance.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_neg_d   = s1_neg_q;
        s1_hi_d    = s1_hi_q;
        s1_rd_d    = s1_rd_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (advance) begin
            s1_valid_d = in_valid;
        end
        if (advance) begin
            s1_a_d   = rs1_mag;
            s1_b_d   = rs2_mag;
            s1_neg_d = rs1_neg ^ rs2_neg;
            s1_hi_d  = (funct3[1:0] != 2'b00);
            s1_rd_d  = rd_addr;
        end
    end

    // S1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_neg_q   <= 1'b0;
            s1_hi_q    <= 1'b0;
            s1_rd_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_neg_q   <= s1_neg_d;
            s1_hi_q    <= s1_hi_d;
            s1_rd_q    <= s1_rd_d;
        end
    end

    // ---------------- multiplier core ----------------
    logic [63:0] core_prod;

    dadda_tree u_dadda_tree (
        .a_i    (s1_a_q),
        .b_i    (s1_b_q),
        .prod_o (core_prod)
    );

    // ---------------- stage S2 ----------------
    logic        s2_valid_q, s2_valid_d;
    logic [63:0] s2_prod_q, s2_prod_d;
    logic        s2_neg_q, s2_neg_d;
    logic        s2_hi_q, s2_hi_d;
    logic [4:0]  s2_rd_q, s2_rd_d;

    // S2 next state. It takes a bubble whenever S1 is empty.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_prod_d  = s2_prod_q;
        s2_neg_d   = s2_neg_q;
        s2_hi_d    = s2_hi_q;
        s2_rd_d    = s2_rd_q;
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (advance) begin
            s2_valid_d = s1_valid_q;
        end
        if (advance) begin
            s2_prod_d = core_prod;
            s2_neg_d  = s1_neg_q;
            s2_hi_d   = s1_hi_q;
            s2_rd_d   = s1_rd_q;
        end
    end

    // S2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_neg_q   <= 1'b0;
            s2_hi_q    <= 1'b0;
            s2_rd_q    <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_prod_q  <= s2_prod_d;
            s2_neg_q   <= s2_neg_d;
            s2_hi_q    <= s2_hi_d;
            s2_rd_q    <= s2_rd_d;
        end
    end

    // ---------------- sign fix-up and word select ----------------
    logic [63:0] fixed_prod;
    logic [31:0] result_word;

    // Restore the sign with a 64-bit two's-complement negate, then pick a
    // half of the product.
    always_comb begin
        fixed_prod  = s2_neg_q ? (~s2_prod_q + 64'd1) : s2_prod_q;
        result_word = s2_hi_q ? fixed_prod[63:32] : fixed_prod[31:0];
    end

`ifdef MUL_OUT_REG_EN
    // ---------------- stage S3: registered output ----------------
    logic        s3_valid_q, s3_valid_d;
    logic [31:0] s3_data_q, s3_data_d;
    logic [4:0]  s3_rd_q, s3_rd_d;

    // S3 next state. It follows the same advance and flush rules.
    always_comb begin
        s3_valid_d = s3_valid_q;
        s3_data_d  = s3_data_q;
        s3_rd_d    = s3_rd_q;
        if (flush) begin
            s3_valid_d = 1'b0;
        end else if (advance) begin
            s3_valid_d = s2_valid_q;
        end
        if (advance) begin
            s3_data_d = result_word;
            s3_rd_d   = s2_rd_q;
        end
    end

    // S3 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_q <= 1'b0;
            s3_data_q  <= '0;
            s3_rd_q    <= '0;
        end else begin
            s3_valid_q <= s3_valid_d;
            s3_data_q  <= s3_data_d;
            s3_rd_q    <= s3_rd_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign out_data  = s3_data_q;
    assign out_rd    = s3_rd_q;
    assign busy      = s1_valid_q || s2_valid_q || s3_valid_q;
`else
    assign out_valid = s2_valid_q;
    assign out_data  = result_word;
    assign out_rd    = s2_rd_q;
    assign busy      = s1_valid_q || s2_valid_q;
`endif

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Bench for mul_pipe_ctrl. A behavioural model holds the expected contents of
// the pipe. It is a list of op results indexed by age, and the product is
// computed with sign-extended 64-bit arithmetic. The model is compared against
// the DUT on every falling edge. Directed cases pin the model with literal
// values. A randomized phase then follows.
`timescale 1ns/1ps
module tb_mul_pipe_ctrl;
`ifdef MUL_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [2:0]  funct3;
    logic [4:0]  rd_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        busy;

    mul_pipe_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .funct3    (funct3),
        .rd_addr   (rd_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: slot LAT-1 is the oldest op and drives the outputs.
    logic        mv [0:2];
    logic [31:0] md [0:2];
    logic [4:0]  mr [0:2];
    logic        last_accept;
    logic [4:0]  seen_rd;
    logic        saw_in_ready_low;
    logic [4:0]  retired [$];

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f);
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] p;
        case (f[1:0])
            2'b01:   begin x = {{32{a[31]}}, a}; y = {{32{b[31]}}, b}; end
            2'b10:   begin x = {{32{a[31]}}, a}; y = {32'd0, b}; end
            default: begin x = {32'd0, a};       y = {32'd0, b}; end
        endcase
        p = x * y;
        return (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mv[i] = 1'b0; md[i] = '0; mr[i] = '0;
        end
    endtask

    // Apply one clock edge to the model, using the inputs the TB is driving.
    task automatic model_edge();
        logic adv;
        adv = !mv[LAT-1] || out_ready;
        last_accept = 1'b0;
        if (adv && mv[LAT-1]) retired.push_back(seen_rd);
        if (flush) begin
            for (int i = 0; i < LAT; i++) mv[i] = 1'b0;
        end else if (adv) begin
            for (int i = LAT-1; i > 0; i--) begin
                mv[i] = mv[i-1]; md[i] = md[i-1]; mr[i] = mr[i-1];
            end
            mv[0] = in_valid;
            md[0] = ref_mul(rs1_data, rs2_data, funct3);
            mr[0] = rd_addr;
            last_accept = in_valid;
        end
    endtask

    // Compare the DUT outputs against the model (called on the falling edge).
    task automatic compare();
        logic any;
        any = 1'b0;
        for (int i = 0; i < LAT; i++) any = any | mv[i];
        chk("out_valid", {31'd0, out_valid}, {31'd0, mv[LAT-1]});
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!mv[LAT-1] || out_ready)});
        chk("busy", {31'd0, busy}, {31'd0, any});
        if (mv[LAT-1]) begin
            chk("out_data", out_data, md[LAT-1]);
            chk("out_rd", {27'd0, out_rd}, {27'd0, mr[LAT-1]});
        end
        if (!in_ready) saw_in_ready_low = 1'b1;
        seen_rd = out_rd;
    endtask

    task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f, input logic [4:0] rd,
                       input logic ordy, input logic fl);
        in_valid = v; rs1_data = a; rs2_data = b; funct3 = f; rd_addr = rd;
        out_ready = ordy; flush = fl;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 32'd0, 32'd0, 3'd0, 5'd0, ordy, 1'b0);
    endtask

    // Issue one op into an empty pipe and check the literal result at the
    // expected latency.
    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] f, input logic [4:0] rd, input logic [31:0] exp);
        cyc(1'b1, a, b, f, rd, 1'b1, 1'b0);
        chk({name, "_early"}, {31'd0, out_valid}, 32'd0);
        repeat (LAT-1) idle(1'b1);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk(name, out_data, exp);
        chk({name, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
        idle(1'b1);
    endtask

    task automatic rand_operand(output logic [31:0] v);
        case ($urandom_range(0, 5))
            0: v = 32'h8000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'd0;
            3: v = $urandom_range(0, 15);
            default: v = $urandom;
        endcase
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  next_tag;
        int          guard;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rs1_data = '0; rs2_data = '0; funct3 = '0; rd_addr = '0;
        model_reset();
        seen_rd = '0;
        saw_in_ready_low = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Literal results. They pin both the DUT and ref_mul.
        directed("mul_7xm3", 32'h0000_0007, 32'hFFFF_FFFD, 3'b000, 5'd9, 32'hFFFF_FFEB);
        directed("mulh_min", 32'h8000_0000, 32'h8000_0000, 3'b001, 5'd3, 32'h4000_0000);
        directed("mulh_m1x2", 32'hFFFF_FFFF, 32'h0000_0002, 3'b001, 5'd4, 32'hFFFF_FFFF);
        directed("mulhsu_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 5'd5, 32'hFFFF_FFFF);
        directed("mulhu_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 5'd6, 32'hFFFF_FFFE);

        // Back-to-back MULs with tags 1..4 and a 5-cycle stall mid-stream.
        retired.delete();
        saw_in_ready_low = 1'b0;
        next_tag = 5'd1;
        for (int c = 0; c < 30 && retired.size() < 4; c++) begin
            logic ordy;
            ordy = !(c >= 2 && c < 7);
            if (next_tag <= 5'd4)
                cyc(1'b1, 32'd100 + {27'd0, next_tag}, 32'd3, 3'b000, next_tag, ordy, 1'b0);
            else
                idle(ordy);
            if (last_accept) next_tag = next_tag + 5'd1;
        end
        chk("bp_in_ready_dropped", {31'd0, saw_in_ready_low}, 32'd1);
        chk("bp_retired_count", retired.size(), 32'd4);
        for (int i = 0; i < 4 && i < retired.size(); i++)
            chk("bp_order", {27'd0, retired[i]}, i + 1);
        idle(1'b1);

        // Flush with 2 ops in flight and a concurrent in_valid.
        cyc(1'b1, 32'd5, 32'd6, 3'b000, 5'd11, 1'b0, 1'b0);
        cyc(1'b1, 32'd7, 32'd8, 3'b000, 5'd12, 1'b0, 1'b0);
        cyc(1'b1, 32'd9, 32'd9, 3'b000, 5'd13, 1'b0, 1'b1);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        idle(1'b1);
        chk("flush_stays_empty", {31'd0, out_valid}, 32'd0);
        directed("post_flush", 32'd12, 32'd12, 3'b000, 5'd14, 32'd144);

        // Asynchronous reset mid-pipeline.
        cyc(1'b1, 32'd2, 32'd3, 3'b000, 5'd20, 1'b0, 1'b0);
        cyc(1'b1, 32'd4, 32'd5, 3'b000, 5'd21, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_out_data", out_data, 32'd0);
        chk("arst_out_rd", {27'd0, out_rd}, 32'd0);
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 1) idle(1'b1);
        directed("post_reset", 32'hFFFF_FFFE, 32'd3, 3'b001, 5'd22, 32'hFFFF_FFFF);

        // Randomized traffic with backpressure and occasional flushes.
        guard = 0;
        for (int n = 0; n < 600; n++) begin
            rand_operand(a);
            rand_operand(b);
            cyc($urandom_range(0, 3) != 0, a, b, {1'b0, 2'($urandom_range(0, 3))},
                5'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
        end
        while (busy && guard < 20) begin
            idle(1'b1);
            guard++;
        end
        chk("drain_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
